div_radix2: RTL and testbench

Iterative 32-bit radix-2 restoring divider for the EX stage. It serves DIV/DIVU. The EX multiply/divide unit holds `en` high while a divide instruction occupies EX and stalls the pipeline until `complete` is high. On that cycle it writes `quotient` into LO and `remainder` into HI. The block costs one fixed-latency iteration per quotient bit, so it needs no wide array divider on the critical path.

---
 rtl/div_radix2_pkg.sv | 13 +
 rtl/div_radix2_if.sv | 22 ++
 rtl/div_radix2_step.sv | 24 ++
 rtl/div_radix2.sv | 123 ++++++++++++
 tb/tb_div_radix2.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/div_radix2_pkg.sv
// Shared constants and state encoding for the radix-2 restoring divider.
package div_radix2_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_radix2_if.sv
// Request/result bundle between the EX mul/div unit and the divider.
interface div_radix2_if #(parameter int WIDTH = 32);

    logic             en;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             complete;

    modport master (
        output en, is_signed, dividend, divisor,
        input  quotient, remainder, complete
    );

    modport slave (
        input  en, is_signed, dividend, divisor,
        output quotient, remainder, complete
    );

endinterface

// File: rtl/div_radix2_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// |divisor|, keep the difference if it did not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Two guard bits so the borrow of the trial subtraction is never ambiguous.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {2'b00, dsr};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// operands made absolute on capture, signs reapplied when results are loaded.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic      clk,
    input  logic      reset,
    div_radix2_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state, state_nxt;
    logic [WIDTH:0]   prem;
    logic [WIDTH:0]   prem_nxt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [CNT_W-1:0] cnt;
    logic             q_neg, r_neg, dz;
    logic             rearm;
    logic             q_bit;
    logic             start, last_step;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] q_fin, r_fin;
    logic [WIDTH-1:0] quotient_q, remainder_q;

    // Operand magnitudes; |most-negative| fits because the result is unsigned.
    always_comb begin
        a_neg = bus.is_signed & bus.dividend[WIDTH-1];
        b_neg = bus.is_signed & bus.divisor[WIDTH-1];
        abs_a = a_neg ? -bus.dividend : bus.dividend;
        abs_b = b_neg ? -bus.divisor  : bus.divisor;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem),
        .bit_in  (dvd[WIDTH-1]),
        .dsr     (dsr),
        .rem_out (prem_nxt),
        .q_bit   (q_bit)
    );

    // The IDLE cycle right after DONE does not accept a request, giving the
    // 35-cycle back-to-back issue interval the EX stage is timed for.
    assign start     = (state == DIV_IDLE) && bus.en && !rearm;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign q_fin     = {dvd[WIDTH-2:0], q_bit};
    assign r_fin     = prem_nxt[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= DIV_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: abort on en low while busy, DONE always lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = DIV_BUSY;
            DIV_BUSY: begin
                if (!bus.en)        state_nxt = DIV_IDLE;
                else if (last_step) state_nxt = DIV_DONE;
            end
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // Datapath: capture, iterate, and load sign-corrected results on the last step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prem        <= '0;
            dvd         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            rearm       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    rearm <= 1'b0;
                    if (start) begin
                        dvd   <= abs_a;
                        dsr   <= abs_b;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        dz    <= (bus.divisor == '0);
                        prem  <= '0;
                        cnt   <= '0;
                    end
                end
                DIV_BUSY: begin
                    if (bus.en) begin
                        prem <= prem_nxt;
                        dvd  <= q_fin;
                        cnt  <= cnt + 1'b1;
                        if (last_step) begin
                            // Zero divisor: the loop yields |dividend| as remainder,
                            // so negating by the dividend sign restores the original.
                            quotient_q  <= dz ? '1 : (q_neg ? -q_fin : q_fin);
                            remainder_q <= r_neg ? -r_fin : r_fin;
                        end
                    end
                end
                DIV_DONE: rearm <= 1'b1;
                default:  rearm <= 1'b0;
            endcase
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.complete  = (state == DIV_DONE);

endmodule

// File: tb/tb_div_radix2.sv
// Randomized and directed checks of div_radix2 against a plain-arithmetic model.
module tb_div_radix2;

    logic clk = 1'b0;
    logic reset;

    div_radix2_if #(.WIDTH(32)) bus ();

    div_radix2 #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: divide-by-zero rule, otherwise SV truncating division.
    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue one divide from IDLE, scramble operands after the start edge,
    // expect complete in cycle 33 and nothing in cycle 34.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
        logic [31:0] eq, er;
        int done_at;
        ref_div(sgn, a, b, eq, er);
        bus.en = 1'b0;
        tick();
        tick();
        bus.en        = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        done_at = -1;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            tick();
            if (k == 1) begin
                bus.dividend  = $urandom;
                bus.divisor   = $urandom;
                bus.is_signed = ~sgn;
            end
            if (bus.complete === 1'b1) done_at = k;
        end
        chk({tag, " latency"}, 64'(done_at), 64'd33);
        chk({tag, " quotient"}, 64'(bus.quotient), 64'(eq));
        chk({tag, " remainder"}, 64'(bus.remainder), 64'(er));
        bus.en = 1'b0;
        tick();
        chk({tag, " complete_c34"}, 64'(bus.complete), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        bit sgn;
        int sel, seen, hold_bad;
        int pulses[$];

        reset         = 1'b0;
        bus.en        = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        tick();
        tick();
        chk("reset quotient", 64'(bus.quotient), 64'd0);
        chk("reset remainder", 64'(bus.remainder), 64'd0);
        chk("reset complete", 64'(bus.complete), 64'd0);
        reset = 1'b1;

        // Directed corner cases.
        run_div(1'b0, 32'd100, 32'd7, "udiv_100_7");
        run_div(1'b1, -32'sd7, 32'd2, "sdiv_m7_2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_ovf");
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "udiv_ovf");
        run_div(1'b1, 32'h1234_5678, 32'd0, "sdiv_zero");
        run_div(1'b0, 32'h1234_5678, 32'd0, "udiv_zero");
        run_div(1'b1, 32'hFFFF_FF00, 32'd0, "sdiv_zero_neg");

        // Random operands biased toward small, negative and zero divisors.
        repeat (30) begin
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = 32'd0;
            else if (sel < 3)  b = 32'($urandom_range(1, 15));
            else if (sel == 3) b = -32'($urandom_range(1, 9));
            else               b = $urandom >> $urandom_range(0, 31);
            run_div(sgn, a, b, "random");
        end

        // Abort in cycle 10: no complete, outputs hold, then a clean restart.
        run_div(1'b0, 32'd1000, 32'd10, "pre_abort");
        bus.en = 1'b0;
        tick();
        tick();
        bus.en       = 1'b1;
        bus.dividend = 32'd12345;
        bus.divisor  = 32'd7;
        for (int k = 1; k <= 10; k++) tick();
        bus.en   = 1'b0;
        seen     = 0;
        hold_bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.complete === 1'b1) seen++;
            if (bus.quotient !== 32'd100 || bus.remainder !== 32'd0) hold_bad++;
        end
        chk("abort no complete", 64'(seen), 64'd0);
        chk("abort outputs hold", 64'(hold_bad), 64'd0);
        run_div(1'b0, 32'd9, 32'd3, "restart_9_3");

        // Reset in cycle 20 of a divide clears the outputs.
        run_div(1'b0, 32'd100, 32'd7, "pre_reset");
        bus.en = 1'b0;
        tick();
        tick();
        bus.en       = 1'b1;
        bus.dividend = 32'd5000;
        bus.divisor  = 32'd3;
        for (int k = 1; k <= 20; k++) tick();
        reset = 1'b0;
        tick();
        chk("midreset quotient", 64'(bus.quotient), 64'd0);
        chk("midreset remainder", 64'(bus.remainder), 64'd0);
        chk("midreset complete", 64'(bus.complete), 64'd0);
        reset  = 1'b1;
        bus.en = 1'b0;
        run_div(1'b1, -32'sd100, 32'd7, "post_reset");

        // Back-to-back with en held: pulses in cycles 33 and 68.
        bus.en = 1'b0;
        tick();
        tick();
        bus.en        = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd77;
        bus.divisor   = 32'd4;
        hold_bad      = 0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (bus.complete === 1'b1) pulses.push_back(k);
            if (k == 33) begin
                chk("b2b first quotient", 64'(bus.quotient), 64'd19);
                chk("b2b first remainder", 64'(bus.remainder), 64'd1);
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end
            if (k > 33 && k < 68 && (bus.quotient !== 32'd19 || bus.remainder !== 32'd1))
                hold_bad++;
            if (k == 68) begin
                chk("b2b second quotient", 64'(bus.quotient), 64'd10);
                chk("b2b second remainder", 64'(bus.remainder), 64'd0);
                bus.en = 1'b0;
            end
        end
        chk("b2b hold first result", 64'(hold_bad), 64'd0);
        chk("b2b pulse count", 64'(pulses.size()), 64'd2);
        chk("b2b pulse1 cycle", 64'((pulses.size() > 0) ? pulses[0] : -1), 64'd33);
        chk("b2b pulse2 cycle", 64'((pulses.size() > 1) ? pulses[1] : -1), 64'd68);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
